// File: rtl/imm_decode_queue.sv
// Decodes RV32I/RV64I immediates and branch/jump/AUIPC targets at push, then queues the results.
// One-cycle latency with no bypass; in_ready reflects queue space only, and a full queue stalls upstream.
module imm_decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    logic [31:0]     raw_imm;
    logic [2:0]      dec_type;
    logic            dec_illegal;
    logic            dec_has_target;
    logic [XLEN-1:0] dec_imm;
    entry_t          dec_entry;
    entry_t          head;
    entry_t          mem [DEPTH];

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    always_comb begin
        raw_imm        = '0;
        dec_type       = T_NONE;
        dec_illegal    = 1'b0;
        dec_has_target = 1'b0;
        case (in_instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                raw_imm  = {{20{in_instr[31]}}, in_instr[31:20]};
                dec_type = T_I;
            end
            OPC_STORE: begin
                raw_imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                dec_type = T_S;
            end
            OPC_BRANCH: begin
                raw_imm        = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0};
                dec_type       = T_B;
                dec_has_target = 1'b1;
            end
            OPC_LUI: begin
                raw_imm  = {in_instr[31:12], 12'b0};
                dec_type = T_U;
            end
            OPC_AUIPC: begin
                raw_imm        = {in_instr[31:12], 12'b0};
                dec_type       = T_U;
                dec_has_target = 1'b1;
            end
            OPC_JAL: begin
                raw_imm        = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0};
                dec_type       = T_J;
                dec_has_target = 1'b1;
            end
            OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: ;
            default: dec_illegal = 1'b1;
        endcase
    end

    // U-type is sign-extended too, so one rule covers every format on RV64.
    always_comb begin
        dec_imm       = {XLEN{raw_imm[31]}};
        dec_imm[31:0] = raw_imm;
    end

    always_comb begin
        dec_entry.imm      = dec_imm;
        dec_entry.imm_type = dec_type;
        dec_entry.target   = dec_has_target ? (in_pc + dec_imm) : '0;
        dec_entry.illegal  = dec_illegal;
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];

    assign out_imm      = out_valid ? head.imm      : '0;
    assign out_imm_type = out_valid ? head.imm_type : T_NONE;
    assign out_target   = out_valid ? head.target   : '0;
    assign out_illegal  = out_valid ? head.illegal  : 1'b0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Slot contents are don't-care once pointers are cleared, so storage has no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec_entry;
    end
endmodule

// File: tb/tb_imm_decode_queue.sv
// Scoreboard bench: instance A is XLEN=32/DEPTH=2, instance B is XLEN=64/DEPTH=4.
module tb_imm_decode_queue;
    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic [63:0] tgt;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_out_illegal;
    logic [31:0] a_in_instr = 0, a_in_pc = 0, a_out_imm, a_out_target;
    logic [2:0]  a_out_imm_type;
    logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_out_illegal;
    logic [31:0] b_in_instr = 0;
    logic [63:0] b_in_pc = 0, b_out_imm, b_out_target;
    logic [2:0]  b_out_imm_type;

    exp_t exp_a, exp_b;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    imm_decode_queue #(.XLEN(32), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_imm_type(a_out_imm_type), .out_target(a_out_target), .out_illegal(a_out_illegal)
    );

    imm_decode_queue #(.XLEN(64), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_imm_type(b_out_imm_type), .out_target(b_out_target), .out_illegal(b_out_illegal)
    );

    function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] typ,
                                input logic [63:0] tgt, input logic ill);
        exp_t e;
        e.imm = imm; e.typ = typ; e.tgt = tgt; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference queues: updated at the edge from the bench's own drive values.
    initial forever @(posedge clk) begin
        if (rst || a_flush) qa.delete();
        else if (a_in_valid && qa.size() < 2) begin
            if (a_out_ready && qa.size() != 0) void'(qa.pop_front());
            qa.push_back(exp_a);
        end else if (a_out_ready && qa.size() != 0) void'(qa.pop_front());

        if (rst || b_flush) qb.delete();
        else if (b_in_valid && qb.size() < 4) begin
            if (b_out_ready && qb.size() != 0) void'(qb.pop_front());
            qb.push_back(exp_b);
        end else if (b_out_ready && qb.size() != 0) void'(qb.pop_front());
    end

    initial forever @(negedge clk) begin
        if (mon_en) begin
            chk("a_in_ready", {63'd0, a_in_ready}, {63'd0, qa.size() < 2});
            chk("a_out_valid", {63'd0, a_out_valid}, {63'd0, qa.size() != 0});
            if (qa.size() != 0) begin
                chk("a_imm", {32'd0, a_out_imm}, qa[0].imm);
                chk("a_type", {61'd0, a_out_imm_type}, {61'd0, qa[0].typ});
                chk("a_target", {32'd0, a_out_target}, qa[0].tgt);
                chk("a_illegal", {63'd0, a_out_illegal}, {63'd0, qa[0].ill});
            end else begin
                chk("a_empty_outs", {a_out_imm, a_out_target}, 64'd0);
                chk("a_empty_flags", {60'd0, a_out_imm_type, a_out_illegal}, 64'd0);
            end
            chk("b_in_ready", {63'd0, b_in_ready}, {63'd0, qb.size() < 4});
            chk("b_out_valid", {63'd0, b_out_valid}, {63'd0, qb.size() != 0});
            if (qb.size() != 0) begin
                chk("b_imm", b_out_imm, qb[0].imm);
                chk("b_type", {61'd0, b_out_imm_type}, {61'd0, qb[0].typ});
                chk("b_target", b_out_target, qb[0].tgt);
                chk("b_illegal", {63'd0, b_out_illegal}, {63'd0, qb[0].ill});
            end else begin
                chk("b_empty_imm", b_out_imm, 64'd0);
                chk("b_empty_tgt", b_out_target, 64'd0);
                chk("b_empty_flags", {60'd0, b_out_imm_type, b_out_illegal}, 64'd0);
            end
        end
    end

    task automatic a_cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input exp_t e, input logic rdy, input logic fl);
        a_in_valid = v; a_in_instr = ins; a_in_pc = pc; exp_a = e;
        a_out_ready = rdy; a_flush = fl;
        @(posedge clk); #1;
    endtask

    task automatic b_cyc(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input exp_t e, input logic rdy, input logic fl);
        b_in_valid = v; b_in_instr = ins; b_in_pc = pc; exp_b = e;
        b_out_ready = rdy; b_flush = fl;
        @(posedge clk); #1;
    endtask

    task automatic a_idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) a_cyc(1'b0, 32'd0, 32'd0, mk(0, 0, 0, 0), rdy, 1'b0);
    endtask

    task automatic b_idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) b_cyc(1'b0, 32'd0, 64'd0, mk(0, 0, 0, 0), rdy, 1'b0);
    endtask

    initial begin
        exp_a = mk(0, 0, 0, 0);
        exp_b = mk(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Decode formats on the 32-bit instance, one entry in flight at a time.
        a_cyc(1, 32'hFFF00093, 32'h0,        mk(64'hFFFFFFFF, 1, 0, 0),          1, 0);
        a_cyc(1, 32'h0080006F, 32'h100,      mk(64'h8, 5, 64'h108, 0),           1, 0);
        a_cyc(1, 32'hFE000EE3, 32'h100,      mk(64'hFFFFFFFC, 3, 64'hFC, 0),     1, 0);
        a_cyc(1, 32'h00112623, 32'h100,      mk(64'hC, 2, 0, 0),                 1, 0);
        a_cyc(1, 32'h00001097, 32'h200,      mk(64'h1000, 4, 64'h1200, 0),       1, 0);
        a_cyc(1, 32'h002081B3, 32'h200,      mk(0, 0, 0, 0),                     1, 0);
        a_cyc(1, 32'hFFFFFFFF, 32'h200,      mk(0, 0, 0, 1),                     1, 0);
        a_cyc(1, 32'hFFC08067, 32'h300,      mk(64'hFFFFFFFC, 1, 0, 0),          1, 0);
        a_cyc(1, 32'h0080006F, 32'hFFFFFFFC, mk(64'h8, 5, 64'h4, 0),             1, 0);
        a_idle(1, 2);

        // Fill with downstream stalled; the third push must be refused.
        a_cyc(1, 32'h00100093, 32'h0, mk(64'h1, 1, 0, 0), 0, 0);
        a_cyc(1, 32'h00200093, 32'h0, mk(64'h2, 1, 0, 0), 0, 0);
        a_cyc(1, 32'h00300093, 32'h0, mk(64'h3, 1, 0, 0), 0, 0);
        a_idle(0, 3);
        a_idle(1, 3);

        // Full queue: push with pop only drains, then flush beats push and pop.
        a_cyc(1, 32'h00400093, 32'h0, mk(64'h4, 1, 0, 0), 0, 0);
        a_cyc(1, 32'h00500093, 32'h0, mk(64'h5, 1, 0, 0), 0, 0);
        a_cyc(1, 32'h00600093, 32'h0, mk(64'h6, 1, 0, 0), 1, 0);
        a_cyc(1, 32'h00700093, 32'h0, mk(64'h7, 1, 0, 0), 0, 0);
        a_cyc(1, 32'h00800093, 32'h0, mk(64'h8, 1, 0, 0), 1, 1);
        a_idle(0, 2);

        // 64-bit instance: sign extension and modular targets.
        b_cyc(1, 32'h80000037, 64'h0,                mk(64'hFFFFFFFF80000000, 4, 0, 0), 1, 0);
        b_cyc(1, 32'h00000000, 64'h0,                mk(0, 0, 0, 1),                    1, 0);
        b_cyc(1, 32'hFFF00093, 64'h0,                mk(64'hFFFFFFFFFFFFFFFF, 1, 0, 0), 1, 0);
        b_cyc(1, 32'hFE000EE3, 64'h100,              mk(64'hFFFFFFFFFFFFFFFC, 3, 64'hFC, 0), 1, 0);
        b_cyc(1, 32'h0080006F, 64'hFFFFFFFFFFFFFFFC, mk(64'h8, 5, 64'h4, 0),            1, 0);
        b_idle(1, 2);

        // Streaming push+pop every cycle at occupancy 1 walks the pointers round twice.
        for (int k = 0; k <= 10; k++)
            b_cyc(1, {k[11:0], 20'h00093}, 64'h0, mk(64'(k), 1, 0, 0), 1, 0);
        b_idle(1, 2);

        // Reset in the middle of a partially filled queue drops everything.
        for (int k = 20; k < 23; k++)
            b_cyc(1, {k[11:0], 20'h00093}, 64'h0, mk(64'(k), 1, 0, 0), 0, 0);
        rst = 1'b1;
        b_cyc(1, 32'h00100093, 64'h0, mk(64'h1, 1, 0, 0), 1, 1);
        rst = 1'b0;
        b_idle(1, 2);
        b_cyc(1, 32'h02A00093, 64'h0, mk(64'h2A, 1, 0, 0), 1, 0);
        b_idle(1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
